// File: rtl/j1_io_pkg.sv
// j1_io_pkg: decode bit positions, status bit indices and FSM encodings for j1_io_uart
package j1_io_pkg;
  localparam int UART_DATA_BIT = 12;
  localparam int UART_STAT_BIT = 13;
  localparam int LED_BIT = 14;
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_OVR = 2;
  localparam int ST_FRM_ERR = 3;
  typedef logic [1:0] tx_state_t;
  typedef logic [1:0] rx_state_t;
  localparam tx_state_t TX_IDLE = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA = 2'd2;
  localparam tx_state_t TX_STOP = 2'd3;
  localparam rx_state_t RX_IDLE = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA = 2'd2;
  localparam rx_state_t RX_STOP = 2'd3;
endpackage

// File: rtl/j1_io_uart_if.sv
// j1_io_uart_if: J1 core I/O strobe bus (strobes, address, write data, read data)
interface j1_io_uart_if;
  logic io_rd;
  logic io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_din;
  modport master (output io_rd, io_wr, io_addr, io_wdata, input io_din);
  modport slave (input io_rd, io_wr, io_addr, io_wdata, output io_din);
endinterface

// File: rtl/j1_uart_rx.sv
// j1_uart_rx: 8N1 receiver with 2-flop synchroniser; pulses rx_strobe or frm_strobe after each stop sample
module j1_uart_rx
  import j1_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frm_strobe
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  logic [1:0] sync;
  logic rx_s;
  rx_state_t state;
  logic [15:0] cnt;
  logic [2:0] bit_cnt;
  assign rx_s = sync[1];
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      sync <= 2'b11;
      state <= RX_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      rx_byte <= '0;
      rx_strobe <= 1'b0;
      frm_strobe <= 1'b0;
    end else begin
      sync <= {sync[0], uart_rx};
      rx_strobe <= 1'b0;
      frm_strobe <= 1'b0;
      if (state == RX_IDLE) begin
        if (!rx_s) begin
          state <= RX_START;
          cnt <= HALF;
        end
      end else if (cnt != 16'd0) cnt <= cnt - 16'd1;
      else begin
        cnt <= FULL;
        case (state)
          RX_START: begin
            state <= rx_s ? RX_IDLE : RX_DATA;
            bit_cnt <= '0;
          end
          RX_DATA: begin
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end
          default: begin
            rx_strobe <= rx_s;
            frm_strobe <= !rx_s;
            state <= RX_IDLE;
          end
        endcase
      end
    end
endmodule

// File: rtl/j1_io_uart.sv
// j1_io_uart: J1 I/O block with 8N1 UART, status and LED port; define J1_IO_RXFIFO_EN for an RX FIFO
// instead of the single-byte RX holding register.
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           resetq,
  j1_io_uart_if.slave    io,
  input  logic           uart_rx,
  output logic           uart_tx,
  output logic [7:0]     leds
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("j1_io_uart: illegal CLKS_PER_BIT or FIFO_DEPTH");
  end
  logic hit_data, hit_stat, hit_led;
  logic pop, push, drop, clr, full, rx_valid, tx_ready, tx_go;
  logic rx_ovr, frm_err, tx_ovr;
  logic [7:0] head, rx_byte;
  logic rx_strobe, frm_strobe;
  logic [15:0] status;
  tx_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic unused_bits;
  assign unused_bits = ^{io.io_addr[15], io.io_addr[11:0], io.io_wdata[15:8]};
  assign hit_data = io.io_addr[UART_DATA_BIT];
  assign hit_stat = !hit_data & io.io_addr[UART_STAT_BIT];
  assign hit_led = !hit_data & !io.io_addr[UART_STAT_BIT] & io.io_addr[LED_BIT];
  assign pop = io.io_rd & hit_data & rx_valid;
  assign push = rx_strobe & (!full | pop);
  assign drop = rx_strobe & full & !pop;
  assign clr = io.io_rd & hit_stat;
  assign tx_ready = tx_state == TX_IDLE;
  assign tx_go = io.io_wr & hit_data & tx_ready;
  always_comb begin
    status = '0;
    status[ST_TX_READY] = tx_ready;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVR] = rx_ovr;
    status[ST_FRM_ERR] = frm_err;
  end
  assign io.io_din = hit_data ? {8'h00, rx_valid ? head : 8'h00} :
                     hit_stat ? status :
                     hit_led ? {8'h00, leds} : 16'h0000;
  j1_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .resetq(resetq),
    .uart_rx(uart_rx),
    .rx_byte(rx_byte),
    .rx_strobe(rx_strobe),
    .frm_strobe(frm_strobe)
  );
`ifdef J1_IO_RXFIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  assign rx_valid = wp != rp;
  assign full = (wp ^ rp) == {1'b1, {PW{1'b0}}};
  assign head = mem[rp[PW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= rx_byte;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop) rp <= rp + ONE;
    end
`else
  logic [7:0] hold;
  logic hold_v;
  assign rx_valid = hold_v;
  assign full = hold_v;
  assign head = hold;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      hold <= '0;
      hold_v <= 1'b0;
    end else begin
      hold_v <= push | (hold_v & !pop);
      if (push) hold <= rx_byte;
    end
`endif
  // flag sets take precedence over a same-edge status-read clear
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_ovr <= 1'b0;
      frm_err <= 1'b0;
      tx_ovr <= 1'b0;
      leds <= 8'h00;
    end else begin
      rx_ovr <= drop | (rx_ovr & !clr);
      frm_err <= frm_strobe | (frm_err & !clr);
      tx_ovr <= tx_ovr | (io.io_wr & hit_data & !tx_ready);
      if (io.io_wr & hit_led) leds <= io.io_wdata[7:0];
    end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      uart_tx <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      if (tx_go) begin
        tx_state <= TX_START;
        tx_cnt <= FULL;
        tx_sh <= io.io_wdata[7:0];
        uart_tx <= 1'b0;
      end
    end else if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
    else begin
      tx_cnt <= FULL;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_bit <= '0;
          uart_tx <= tx_sh[0];
        end
        TX_DATA: begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + 3'd1;
          tx_state <= tx_bit == 3'd7 ? TX_STOP : TX_DATA;
          uart_tx <= tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
endmodule
